// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the tic-tac-toe board scan receiver.
// Cell i = 3*row+col lives at bits [2i+1:2i] of an 18-bit board image.
package tictactoe_pkg;

   typedef enum logic [1:0] {EMPTY = 2'b00, X = 2'b01, O = 2'b10, BAD = 2'b11} cell_t;
   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} rx_state_t;

   localparam int NUM_CELLS = 9;
   localparam int BOARD_W   = 18;

   // Eight winning lines, three 4-bit cell indices each.
   localparam logic [95:0] WIN_LINES = {
      4'd0, 4'd1, 4'd2,   4'd3, 4'd4, 4'd5,   4'd6, 4'd7, 4'd8,
      4'd0, 4'd3, 4'd6,   4'd1, 4'd4, 4'd7,   4'd2, 4'd5, 4'd8,
      4'd0, 4'd4, 4'd8,   4'd2, 4'd4, 4'd6};

   function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
      return ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
   endfunction

   function automatic logic [1:0] idx_row(input logic [3:0] idx);
      return (idx >= 4'd6) ? 2'd2 : (idx >= 4'd3) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [1:0] idx_col(input logic [3:0] idx);
      logic [3:0] rem;
      rem = idx - cell_idx(idx_row(idx), 2'd0);
      return rem[1:0];
   endfunction

   function automatic logic [1:0] win_of(input logic [BOARD_W-1:0] b);
      logic [1:0] w, ca, cb, cc;
      logic [3:0] ia, ib, ic;
      w = 2'b00;
      for (int l = 0; l < 8; l++) begin
         ia = WIN_LINES[12*l+8 +: 4];
         ib = WIN_LINES[12*l+4 +: 4];
         ic = WIN_LINES[12*l   +: 4];
         ca = b[{ia, 1'b0} +: 2];
         cb = b[{ib, 1'b0} +: 2];
         cc = b[{ic, 1'b0} +: 2];
         if (ca != 2'b00 && ca == cb && cb == cc) w = w | ca;
      end
      return w;
   endfunction

endpackage

// File: rtl/board_scan_receiver_if.sv
// Scan bus from the chip plus the receiver's frame/event outputs.
interface board_scan_receiver_if;
   logic [1:0]  scan_xoro;
   logic [1:0]  scan_row;
   logic [1:0]  scan_col;
   logic [17:0] board;
   logic        frame_valid;
   logic        synced;
   logic        sync_err;
   logic        move_valid;
   logic [1:0]  move_row;
   logic [1:0]  move_col;
   logic [1:0]  move_xoro;
   logic        cell_err;
   logic [1:0]  win;

   modport master (
      output scan_xoro, scan_row, scan_col,
      input  board, frame_valid, synced, sync_err, move_valid,
             move_row, move_col, move_xoro, cell_err, win
   );

   modport slave (
      input  scan_xoro, scan_row, scan_col,
      output board, frame_valid, synced, sync_err, move_valid,
             move_row, move_col, move_xoro, cell_err, win
   );
endinterface

// File: rtl/board_frame_diff.sv
// Combinational compare of previous vs new committed board: classifies the
// change as restart, single legal move, or illegal edit.
module board_frame_diff
   import tictactoe_pkg::*;
(
   input  logic [BOARD_W-1:0] prev_i,
   input  logic [BOARD_W-1:0] new_i,
   output logic               restart_o,
   output logic               move_found_o,
   output logic [3:0]         move_idx_o,
   output cell_t              move_cell_o,
   output logic               illegal_o
);

   logic [3:0] adds;
   logic       bad;
   logic [1:0] p, n;

   always_comb begin
      restart_o   = (new_i == '0) && (prev_i != '0);
      adds        = 4'd0;
      bad         = 1'b0;
      move_idx_o  = 4'd0;
      move_cell_o = EMPTY;
      p           = 2'b00;
      n           = 2'b00;
      for (int i = 0; i < NUM_CELLS; i++) begin
         p = prev_i[2*i +: 2];
         n = new_i[2*i +: 2];
         if (p == 2'b00 && n != 2'b00) begin
            adds        = adds + 4'd1;
            move_idx_o  = 4'(i);
            move_cell_o = cell_t'(n);
         end else if (p != 2'b00 && p != n) begin
            bad = 1'b1;
         end
      end
      illegal_o    = !restart_o && (bad || adds >= 4'd2);
      move_found_o = !restart_o && !bad && adds == 4'd1;
   end

endmodule

// File: rtl/board_scan_receiver.sv
// Locks onto the 9-cell scan sweep, commits the board 1 cycle after cell 8 and
// flags moves/errors; BOARD_SCAN_WIN_DETECT_EN adds registered win detection.
module board_scan_receiver
   import tictactoe_pkg::*;
#(
   parameter int SYNC_FRAMES = 2
) (
   input logic                  clk,
   input logic                  reset,
   board_scan_receiver_if.slave bus
);

   rx_state_t          state_q, state_d;
   logic [3:0]         exp_q, exp_d;
   logic [BOARD_W-1:0] shadow_q, shadow_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               fv_q, fv_d, synced_q, synced_d, serr_q, serr_d;
   logic               mv_q, mv_d, cerr_q, cerr_d, prev_valid_q, prev_valid_d;
   logic [1:0]         mrow_q, mrow_d, mcol_q, mcol_d, mxoro_q, mxoro_d;

   logic [3:0]         samp_idx;
   logic               legal, commit, err;
   logic [BOARD_W-1:0] new_img;

   logic       df_restart, df_move, df_illegal;
   logic [3:0] df_idx;
   cell_t      df_cell;

   assign samp_idx = cell_idx(bus.scan_row, bus.scan_col);
   assign legal    = (bus.scan_row != 2'd3) && (bus.scan_col != 2'd3) && (bus.scan_xoro != 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= HUNT;
         exp_q        <= 4'd0;
         shadow_q     <= '0;
         board_q      <= '0;
         cnt_q        <= 4'd0;
         fv_q         <= 1'b0;
         synced_q     <= 1'b0;
         serr_q       <= 1'b0;
         mv_q         <= 1'b0;
         cerr_q       <= 1'b0;
         prev_valid_q <= 1'b0;
         mrow_q       <= 2'd0;
         mcol_q       <= 2'd0;
         mxoro_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         shadow_q     <= shadow_d;
         board_q      <= board_d;
         cnt_q        <= cnt_d;
         fv_q         <= fv_d;
         synced_q     <= synced_d;
         serr_q       <= serr_d;
         mv_q         <= mv_d;
         cerr_q       <= cerr_d;
         prev_valid_q <= prev_valid_d;
         mrow_q       <= mrow_d;
         mcol_q       <= mcol_d;
         mxoro_q      <= mxoro_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      shadow_d = shadow_q;
      commit   = 1'b0;
      err      = 1'b0;
      new_img  = shadow_q;
      for (int i = 0; i < NUM_CELLS; i++)
         if (samp_idx == 4'(i)) new_img[2*i +: 2] = bus.scan_xoro;
      case (state_q)
         HUNT: begin
            if (legal && samp_idx == 4'd0) begin
               shadow_d = {16'd0, bus.scan_xoro};
               exp_d    = 4'd1;
               state_d  = LOCK;
            end
         end
         LOCK: begin
            if (legal && samp_idx == exp_q) begin
               shadow_d = new_img;
               if (exp_q == 4'd8) begin
                  commit = 1'b1;
                  exp_d  = 4'd0;
               end else begin
                  exp_d  = exp_q + 4'd1;
               end
            end else begin
               err = 1'b1;
               // An out-of-place cell 0 is taken as the start of a fresh sweep.
               if (legal && samp_idx == 4'd0) begin
                  shadow_d = {16'd0, bus.scan_xoro};
                  exp_d    = 4'd1;
               end else begin
                  shadow_d = '0;
                  exp_d    = 4'd0;
                  state_d  = HUNT;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   board_frame_diff u_diff (
      .prev_i       (board_q),
      .new_i        (new_img),
      .restart_o    (df_restart),
      .move_found_o (df_move),
      .move_idx_o   (df_idx),
      .move_cell_o  (df_cell),
      .illegal_o    (df_illegal)
   );

   always_comb begin
      board_d      = commit ? new_img : board_q;
      fv_d         = commit;
      serr_d       = err;
      mv_d         = commit && prev_valid_q && df_move;
      cerr_d       = commit && prev_valid_q && df_illegal;
      prev_valid_d = err ? 1'b0 : (commit ? 1'b1 : prev_valid_q);
      cnt_d        = cnt_q;
      if (err)
         cnt_d = 4'd0;
      else if (commit && cnt_q != 4'(SYNC_FRAMES))
         cnt_d = cnt_q + 4'd1;
      synced_d     = (cnt_d == 4'(SYNC_FRAMES));
      mrow_d       = mv_d ? idx_row(df_idx) : mrow_q;
      mcol_d       = mv_d ? idx_col(df_idx) : mcol_q;
      mxoro_d      = mv_d ? df_cell : mxoro_q;
   end

`ifdef BOARD_SCAN_WIN_DETECT_EN
   logic [1:0] win_q;
   always_ff @(posedge clk) begin
      if (reset)       win_q <= 2'b00;
      else if (commit) win_q <= win_of(new_img);
   end
   assign bus.win = win_q;
`else
   assign bus.win = 2'b00;
`endif

   assign bus.board       = board_q;
   assign bus.frame_valid = fv_q;
   assign bus.synced      = synced_q;
   assign bus.sync_err    = serr_q;
   assign bus.move_valid  = mv_q;
   assign bus.move_row    = mrow_q;
   assign bus.move_col    = mcol_q;
   assign bus.move_xoro   = mxoro_q;
   assign bus.cell_err    = cerr_q;

endmodule

// File: tb/tb_board_scan_receiver.sv
// Directed bench for board_scan_receiver: drives scan sweeps and checks frame,
// sync, move, error and win outputs against hand-computed values.
module tb_board_scan_receiver;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic pre_fv;
   logic pre_ev;

`ifdef BOARD_SCAN_WIN_DETECT_EN
   localparam logic [1:0] WIN_EXP = 2'b01;
`else
   localparam logic [1:0] WIN_EXP = 2'b00;
`endif

   board_scan_receiver_if bus ();

   board_scan_receiver #(.SYNC_FRAMES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_raw(input logic [1:0] r, input logic [1:0] c, input logic [1:0] x);
      bus.scan_row  = r;
      bus.scan_col  = c;
      bus.scan_xoro = x;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cell(input int i, input logic [1:0] x);
      drive_raw(2'(i / 3), 2'(i % 3), x);
   endtask

   // Full sweep of cells 0..8; outputs are observed 1 cycle after cell 8.
   task automatic sweep(input logic [17:0] img);
      pre_fv = 1'b0;
      pre_ev = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive_cell(i, img[2*i +: 2]);
         if (i < 8) begin
            pre_fv = pre_fv | bus.frame_valid;
            pre_ev = pre_ev | bus.move_valid | bus.cell_err | bus.sync_err;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.scan_row  = 2'd0;
      bus.scan_col  = 2'd0;
      bus.scan_xoro = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.board !== 18'h0) begin failures++; $display("FAIL reset_board got=%h exp=0", bus.board); end
      checks++;
      if ({bus.frame_valid, bus.synced, bus.sync_err, bus.move_valid, bus.cell_err} !== 5'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=00000",
            {bus.frame_valid, bus.synced, bus.sync_err, bus.move_valid, bus.cell_err});
      end
      checks++;
      if ({bus.move_row, bus.move_col, bus.move_xoro, bus.win} !== 8'h00) begin
         failures++; $display("FAIL reset_move_win got=%h exp=00", {bus.move_row, bus.move_col, bus.move_xoro, bus.win});
      end
      reset = 1'b0;
   endtask

   task automatic test_sync();
      sweep(18'h0);
      checks++;
      if (bus.frame_valid !== 1'b1 || pre_fv !== 1'b0) begin
         failures++; $display("FAIL sync1_fv got=%b pre=%b exp=1 pre=0", bus.frame_valid, pre_fv);
      end
      checks++;
      if (bus.synced !== 1'b0) begin failures++; $display("FAIL sync1_synced got=%b exp=0", bus.synced); end
      sweep(18'h0);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.synced !== 1'b1) begin
         failures++; $display("FAIL sync2 fv=%b synced=%b exp fv=1 synced=1", bus.frame_valid, bus.synced);
      end
      checks++;
      if (bus.board !== 18'h0 || bus.move_valid !== 1'b0 || bus.cell_err !== 1'b0) begin
         failures++; $display("FAIL sync2_board board=%h mv=%b ce=%b exp 0/0/0", bus.board, bus.move_valid, bus.cell_err);
      end
   endtask

   task automatic test_move();
      sweep(18'h00100);
      checks++;
      if (bus.board !== 18'h00100) begin failures++; $display("FAIL move_board got=%h exp=00100", bus.board); end
      checks++;
      if (bus.move_valid !== 1'b1 || bus.frame_valid !== 1'b1 || bus.cell_err !== 1'b0) begin
         failures++; $display("FAIL move_pulse mv=%b fv=%b ce=%b exp 1/1/0", bus.move_valid, bus.frame_valid, bus.cell_err);
      end
      checks++;
      if (bus.move_row !== 2'd1 || bus.move_col !== 2'd1 || bus.move_xoro !== 2'b01) begin
         failures++; $display("FAIL move_loc got r=%0d c=%0d x=%b exp r=1 c=1 x=01", bus.move_row, bus.move_col, bus.move_xoro);
      end
   endtask

   task automatic test_skip();
      for (int i = 0; i < 4; i++) drive_cell(i, 2'b00);
      checks++;
      if (bus.move_valid !== 1'b0 || bus.frame_valid !== 1'b0) begin
         failures++; $display("FAIL move_one_cycle mv=%b fv=%b exp 0/0", bus.move_valid, bus.frame_valid);
      end
      drive_cell(5, 2'b00);
      checks++;
      if (bus.sync_err !== 1'b1 || bus.synced !== 1'b0) begin
         failures++; $display("FAIL skip_err serr=%b synced=%b exp 1/0", bus.sync_err, bus.synced);
      end
      drive_raw(2'd3, 2'd0, 2'b00);
      checks++;
      if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL hunt_illegal serr=%b exp=0", bus.sync_err); end
      drive_cell(7, 2'b00);
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0 || bus.board !== 18'h00100) begin
         failures++; $display("FAIL hunt_ignore fv=%b serr=%b board=%h exp 0/0/00100", bus.frame_valid, bus.sync_err, bus.board);
      end
      sweep(18'h00101);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.board !== 18'h00101 || bus.synced !== 1'b0) begin
         failures++; $display("FAIL resync1 fv=%b board=%h synced=%b exp 1/00101/0", bus.frame_valid, bus.board, bus.synced);
      end
      checks++;
      if (bus.move_valid !== 1'b0 || bus.cell_err !== 1'b0) begin
         failures++; $display("FAIL resync1_nodiff mv=%b ce=%b exp 0/0", bus.move_valid, bus.cell_err);
      end
      sweep(18'h00101);
      checks++;
      if (bus.synced !== 1'b1 || bus.move_valid !== 1'b0) begin
         failures++; $display("FAIL resync2 synced=%b mv=%b exp 1/0", bus.synced, bus.move_valid);
      end
   endtask

   task automatic test_swap();
      sweep(18'h00201);
      checks++;
      if (bus.cell_err !== 1'b1 || bus.move_valid !== 1'b0 || bus.board !== 18'h00201) begin
         failures++; $display("FAIL swap ce=%b mv=%b board=%h exp 1/0/00201", bus.cell_err, bus.move_valid, bus.board);
      end
      checks++;
      if (bus.move_row !== 2'd1 || bus.move_col !== 2'd1 || bus.move_xoro !== 2'b01) begin
         failures++; $display("FAIL move_held got r=%0d c=%0d x=%b exp r=1 c=1 x=01", bus.move_row, bus.move_col, bus.move_xoro);
      end
   endtask

   task automatic test_double();
      sweep(18'h0);
      checks++;
      if (bus.cell_err !== 1'b0 || bus.move_valid !== 1'b0 || bus.frame_valid !== 1'b1) begin
         failures++; $display("FAIL restart1 ce=%b mv=%b fv=%b exp 0/0/1", bus.cell_err, bus.move_valid, bus.frame_valid);
      end
      sweep(18'h20001);
      checks++;
      if (bus.cell_err !== 1'b1 || bus.move_valid !== 1'b0 || bus.board !== 18'h20001) begin
         failures++; $display("FAIL double ce=%b mv=%b board=%h exp 1/0/20001", bus.cell_err, bus.move_valid, bus.board);
      end
      sweep(18'h0);
      checks++;
      if (bus.cell_err !== 1'b0 || bus.move_valid !== 1'b0 || bus.board !== 18'h0 || pre_ev !== 1'b0) begin
         failures++; $display("FAIL restart2 ce=%b mv=%b board=%h pre=%b exp 0/0/0/0", bus.cell_err, bus.move_valid, bus.board, pre_ev);
      end
   endtask

   task automatic test_win();
      sweep(18'h10101);
      checks++;
      if (bus.win !== WIN_EXP || bus.frame_valid !== 1'b1) begin
         failures++; $display("FAIL win_diag win=%b fv=%b exp win=%b fv=1", bus.win, bus.frame_valid, WIN_EXP);
      end
      checks++;
      if (bus.cell_err !== 1'b1 || bus.move_valid !== 1'b0) begin
         failures++; $display("FAIL win_triple ce=%b mv=%b exp 1/0", bus.cell_err, bus.move_valid);
      end
      sweep(18'h0);
      checks++;
      if (bus.win !== 2'b00) begin failures++; $display("FAIL win_clear win=%b exp=00", bus.win); end
   endtask

   task automatic test_restart_capture();
      for (int i = 0; i < 3; i++) drive_cell(i, 2'b00);
      drive_cell(0, 2'b10);
      checks++;
      if (bus.sync_err !== 1'b1 || bus.synced !== 1'b0) begin
         failures++; $display("FAIL idx0_err serr=%b synced=%b exp 1/0", bus.sync_err, bus.synced);
      end
      pre_fv = 1'b0;
      pre_ev = 1'b0;
      for (int i = 1; i < 9; i++) begin
         drive_cell(i, 2'b00);
         if (i < 8) begin
            pre_fv = pre_fv | bus.frame_valid;
            pre_ev = pre_ev | bus.sync_err;
         end
      end
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.board !== 18'h00002 || pre_fv !== 1'b0 || pre_ev !== 1'b0) begin
         failures++; $display("FAIL idx0_recapture fv=%b board=%h pre_fv=%b pre_serr=%b exp 1/00002/0/0",
            bus.frame_valid, bus.board, pre_fv, pre_ev);
      end
      checks++;
      if (bus.move_valid !== 1'b0 || bus.cell_err !== 1'b0) begin
         failures++; $display("FAIL idx0_nodiff mv=%b ce=%b exp 0/0", bus.move_valid, bus.cell_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      sweep(18'h00006);
      for (int i = 0; i < 5; i++) drive_cell(i, 2'b00);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.board !== 18'h0 || bus.synced !== 1'b0 || bus.frame_valid !== 1'b0 || bus.move_xoro !== 2'b00) begin
         failures++; $display("FAIL midreset board=%h synced=%b fv=%b mx=%b exp 0/0/0/00",
            bus.board, bus.synced, bus.frame_valid, bus.move_xoro);
      end
      reset = 1'b0;
      sweep(18'h00004);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.board !== 18'h00004 || bus.synced !== 1'b0 || bus.move_valid !== 1'b0) begin
         failures++; $display("FAIL post_reset fv=%b board=%h synced=%b mv=%b exp 1/00004/0/0",
            bus.frame_valid, bus.board, bus.synced, bus.move_valid);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      test_reset();
      test_sync();
      test_move();
      test_skip();
      test_swap();
      test_double();
      test_win();
      test_restart_capture();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
